sim_time_base: RTL and testbench

//  Clocked time base plus one-shot wait timer. Replaces the behavioural now()/waitTime() helper

---
 rtl/sim_time_pkg.sv | 19 +
 rtl/sim_time_wait_timer.sv | 97 +++++++++
 rtl/sim_time_base.sv | 51 +++++
 tb/tb_sim_time_base.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sim_time_pkg.sv
// Shared types and helpers for the simulation time base.
package sim_time_pkg;

  typedef logic [63:0] sim_time_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } wait_state_e;

  localparam sim_time_t PS_PER_SEC = 64'd1_000_000_000_000;

  // Clock period in ps for a given frequency in Hz (1 MHz -> 1_000_000 ps).
  function automatic sim_time_t freq2period(input sim_time_t freq_hz);
    return PS_PER_SEC / freq_hz;
  endfunction

endpackage

// File: rtl/sim_time_wait_timer.sv
// One-shot wait timer: IDLE -> WAIT -> DONE -> IDLE.
// Optional macro SIM_TIME_ABS_WAIT_EN adds absolute-deadline waits.
module sim_time_wait_timer
  import sim_time_pkg::*;
#(
  parameter int unsigned TIME_W        = 64,
  parameter int unsigned CLK_PERIOD_PS = 1000
) (
  input  logic              clk_i,
  input  logic              rst_i,
`ifdef SIM_TIME_ABS_WAIT_EN
  input  logic [TIME_W-1:0] now_i,
  input  logic              wait_abs_i,
`endif
  input  logic              wait_req_i,
  input  logic [TIME_W-1:0] wait_time_i,
  output logic              wait_busy_o,
  output logic              wait_done_o
);

  localparam logic [TIME_W-1:0] PERIOD = TIME_W'(CLK_PERIOD_PS);

  wait_state_e       state_q, state_d;
  logic [TIME_W-1:0] rem_q, rem_d;
  logic              expire;
`ifdef SIM_TIME_ABS_WAIT_EN
  logic              abs_q, abs_d;
`endif

  // Expiry test for the current WAIT cycle.
  // Absolute waits compare against the time the next edge will publish, so DONE
  // coincides with the cycle in which now reaches the deadline.
  always_comb begin
`ifdef SIM_TIME_ABS_WAIT_EN
    expire = abs_q ? ((now_i + PERIOD) >= rem_q) : (rem_q <= PERIOD);
`else
    expire = (rem_q <= PERIOD);
`endif
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
`ifdef SIM_TIME_ABS_WAIT_EN
    abs_d       = abs_q;
`endif
    wait_busy_o = 1'b0;
    wait_done_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (wait_req_i) begin
          rem_d   = wait_time_i;
`ifdef SIM_TIME_ABS_WAIT_EN
          abs_d   = wait_abs_i;
`endif
          state_d = WAIT;
        end
      end
      WAIT: begin
        wait_busy_o = 1'b1;
        if (expire) begin
          state_d = DONE;
        end else begin
`ifdef SIM_TIME_ABS_WAIT_EN
          if (!abs_q) rem_d = rem_q - PERIOD;
`else
          rem_d = rem_q - PERIOD;
`endif
        end
      end
      DONE: begin
        wait_done_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and remaining/deadline registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
`ifdef SIM_TIME_ABS_WAIT_EN
      abs_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
`ifdef SIM_TIME_ABS_WAIT_EN
      abs_q   <= abs_d;
`endif
    end
  end

endmodule

// File: rtl/sim_time_base.sv
// Clocked time base (cycles and ps) plus one-shot wait timer.
// Optional macro SIM_TIME_ABS_WAIT_EN adds port wait_abs_i for absolute deadlines.
module sim_time_base
  import sim_time_pkg::*;
#(
  parameter int unsigned TIME_W        = 64,
  parameter int unsigned CLK_PERIOD_PS = 1000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [TIME_W-1:0] now_o,
  output logic [TIME_W-1:0] cycles_o,
  input  logic              wait_req_i,
  input  logic [TIME_W-1:0] wait_time_i,
`ifdef SIM_TIME_ABS_WAIT_EN
  input  logic              wait_abs_i,
`endif
  output logic              wait_busy_o,
  output logic              wait_done_o
);

  localparam logic [TIME_W-1:0] PERIOD = TIME_W'(CLK_PERIOD_PS);

  // Free-running counters; both wrap modulo 2^TIME_W.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      now_o    <= '0;
      cycles_o <= '0;
    end else begin
      now_o    <= now_o + PERIOD;
      cycles_o <= cycles_o + 1'b1;
    end
  end

  sim_time_wait_timer #(
    .TIME_W        (TIME_W),
    .CLK_PERIOD_PS (CLK_PERIOD_PS)
  ) u_wait_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
`ifdef SIM_TIME_ABS_WAIT_EN
    .now_i       (now_o),
    .wait_abs_i  (wait_abs_i),
`endif
    .wait_req_i  (wait_req_i),
    .wait_time_i (wait_time_i),
    .wait_busy_o (wait_busy_o),
    .wait_done_o (wait_done_o)
  );

endmodule

// File: tb/tb_sim_time_base.sv
// Scoreboard bench for sim_time_base: a cycle-level reference model predicts the
// cycle in which each accepted wait completes; a negedge monitor checks outputs.
module tb_sim_time_base;

  localparam longint unsigned P = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [63:0] wtime = '0;
  logic        abs_bit = 1'b0;
  logic [63:0] now, cycles;
  logic        busy, done;

  always #5 clk = ~clk;

  sim_time_base #(
    .TIME_W        (64),
    .CLK_PERIOD_PS (1000)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .now_o       (now),
    .cycles_o    (cycles),
    .wait_req_i  (req),
    .wait_time_i (wtime),
`ifdef SIM_TIME_ABS_WAIT_EN
    .wait_abs_i  (abs_bit),
`endif
    .wait_busy_o (busy),
    .wait_done_o (done)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: cycles since reset, and cycle in which the active wait shows DONE.
  longint unsigned tb_cyc = 0;
  longint unsigned due = 0;
  bit              active = 1'b0;
  bit              started = 1'b0;
  longint unsigned exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, tb_cyc);
    end
  endtask

  // Reference model: a wait of d ps accepted in cycle c shows DONE in cycle
  // c+1+max(1,ceil(d/P)); an absolute deadline D shows DONE in the first cycle x>=c+2
  // with x*P>=D. Requests are only taken when no wait is pending or DONE is past.
  always @(posedge clk) begin
    longint unsigned c, w;
    if (rst) begin
      tb_cyc  = 0;
      active  = 1'b0;
      exp_q.delete();
      started = 1'b1;
    end else if (started) begin
      c = tb_cyc;
      if (req && (!active || c > due)) begin
`ifdef SIM_TIME_ABS_WAIT_EN
        if (abs_bit) begin
          w   = (wtime + P - 1) / P;
          due = (w > c + 2) ? w : c + 2;
        end else
`endif
        begin
          w = (wtime + P - 1) / P;
          if (w == 0) w = 1;
          due = c + 1 + w;
        end
        active = 1'b1;
        exp_q.push_back(due);
      end
      tb_cyc = c + 1;
    end
  end

  // Monitor: compares every cycle away from the active edge.
  always @(negedge clk) begin
    logic exp_done;
    if (started) begin
      chk("now", now, tb_cyc * P);
      chk("cycles", cycles, tb_cyc);
      chk("busy", {63'b0, busy}, {63'b0, (active && tb_cyc < due)});
      exp_done = (exp_q.size() != 0) && (exp_q[0] == tb_cyc);
      chk("done", {63'b0, done}, {63'b0, exp_done});
      if (exp_q.size() != 0 && exp_q[0] <= tb_cyc) void'(exp_q.pop_front());
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input longint unsigned d);
    req = 1'b1; wtime = d; abs_bit = 1'b0;
    cyc(1);
    req = 1'b0;
  endtask

  initial begin
    longint unsigned dl;
    cyc(2);
    rst = 1'b0;
    cyc(5);                      // now=5000, cycles=5
    rst = 1'b1; cyc(1); rst = 1'b0;
    issue(3500);  cyc(8);        // 4 busy cycles, done 5 cycles after req
    issue(0);     cyc(4);
    issue(1000);  cyc(4);
    issue(10000); cyc(1);
    issue(2000);  cyc(14);       // second req ignored
    issue(8000);  cyc(3);
    rst = 1'b1; cyc(1); rst = 1'b0;  // abort mid-wait
    cyc(3);
`ifdef SIM_TIME_ABS_WAIT_EN
    rst = 1'b1; cyc(1); rst = 1'b0;
    cyc(2);                      // now=2000
    req = 1'b1; abs_bit = 1'b1; wtime = 64'd6000;
    cyc(1);
    req = 1'b0; abs_bit = 1'b0;
    cyc(6);
    req = 1'b1; abs_bit = 1'b1; wtime = 64'd1000;
    cyc(1);
    req = 1'b0; abs_bit = 1'b0;
    cyc(4);
`endif
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 59) == 0);
      req   = ($urandom_range(0, 2) == 0);
      wtime = 64'($urandom_range(0, 12000));
      abs_bit = 1'b0;
`ifdef SIM_TIME_ABS_WAIT_EN
      abs_bit = $urandom_range(0, 1) == 1;
      if (abs_bit) begin
        dl = tb_cyc * P + longint'($urandom_range(0, 12000));
        wtime = (dl > 4000) ? dl - 4000 : 0;
      end
`endif
      cyc(1);
    end
    rst = 1'b0; req = 1'b0; abs_bit = 1'b0;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) cyc(1);
    chk("drain", 64'(exp_q.size()), 64'd0);
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
